swap_responder: RTL and testbench
=================================

Name: swap_responder

Overview:
- Responder end of the register-exchange protocol: an initiator issues write/swap/rotate/read commands over a valid/ready request channel, and this block executes them on an internal register bank.
- Returns exactly one response per accepted command on a valid/ready response channel.
- All bank updates use non-blocking semantics, so every exchange is race-free: both entries take each other's pre-edge values.
- Sits beside exchange test structures as the synthesizable exchange engine.

Parameters:
WIDTH, 8, data width of each bank entry
DEPTH, 4, number of bank entries (need not be a power of 2)
IDXW, 2, index width; must satisfy 2**IDXW >= DEPTH

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  command accepted on the edge where req_valid && req_ready
req_op  input  2  00 WRITE, 01 SWAP, 10 ROTATE, 11 READ
req_idx_a  input  IDXW  first index
req_idx_b  input  IDXW  second index (SWAP only)
req_data  input  WIDTH  write data (WRITE); rotate count in [IDXW-1:0] (ROTATE)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed on the edge where rsp_valid && rsp_ready
rsp_data  output  WIDTH  response data
rsp_err  output  1  command rejected, bank unchanged

Behaviour:
- Reset (async, rst_n=0):
  - All entries = 0, state = IDLE.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, req_ready = 0 while rst_n = 0.
  - Reset mid-rotate abandons the command: no response, bank zeroed.
- States: IDLE, ROT, RESP.
  - req_ready = 1 only in IDLE with rst_n = 1.
- IDLE, command accepted at edge N:
  - Index check: req_idx_a >= DEPTH, or (SWAP and req_idx_b >= DEPTH), gives rsp_err=1, rsp_data=0, no bank change, go to RESP at edge N. Applies to all ops.
  - WRITE: entry[a] <= req_data; rsp_data = old entry[a]; go to RESP.
  - SWAP: entry[a] <= entry[b] and entry[b] <= entry[a] on the same edge; rsp_data = old entry[a]; go to RESP. If a == b, the bank is unchanged.
  - READ: rsp_data = entry[a]; go to RESP.
  - ROTATE, k = req_data[IDXW-1:0]:
    - k = 0: no change; rsp_data = entry[0]; go to RESP.
    - k >= 1: latch k, go to ROT.
- ROT: one step per cycle, entry[(i+1) mod DEPTH] <= entry[i] for all i simultaneously.
  - Steps occur at edges N+1 .. N+k.
  - At edge N+k, go to RESP; rsp_data = entry[0] after the final step.
  - k >= DEPTH is legal: k full steps are still executed.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_err are stable until the handshake.
  - On rsp_valid && rsp_ready, return to IDLE at that edge; rsp_valid drops the next cycle.
  - No new command is accepted in RESP, so there is no back-to-back overlap.
- Latency:
  - Non-rotate commands: rsp_valid is high from edge N+1.
  - Rotate with k >= 1: rsp_valid is high after edge N+k.
- rsp_err is cleared on response handshake, not at command acceptance.
- req_* inputs are ignored unless req_valid && req_ready.

Optional Feature:
- Macro: SWAP_RESP_ROT_DIR_EN.
- Defined:
  - ROTATE uses req_data[WIDTH-1] as the direction. 0 = up (as above). 1 = down: entry[i] <= entry[(i+1) mod DEPTH].
  - The direction is latched at acceptance.
  - rsp_data is still entry[0] after the final step.
- Not defined:
  - req_data[WIDTH-1] is ignored for ROTATE; rotation is always up.

Test Plan:
- Reset release, then WRITE idx0..3 with 0x11, 0x22, 0x33, 0x44 -> each rsp_data = 0x00, rsp_err = 0, rsp_valid one cycle after accept.
- SWAP a=1, b=3 -> rsp_data = 0x22; READ 1 -> 0x44; READ 3 -> 0x22; SWAP a=2, b=2 -> bank unchanged, READ 2 = 0x33.
- ROTATE k=1 on {0x11,0x22,0x33,0x44} -> bank {0x44,0x11,0x22,0x33}, rsp_data = 0x44. ROTATE k=3 -> req_ready low for 3 cycles, then rsp_data = 0x11.
- Hold rsp_ready = 0 for 5 cycles after a READ -> rsp_valid and rsp_data stable, req_ready = 0 throughout; a req_valid pulse during this time is not accepted.
- DEPTH=3 build, SWAP a=0, b=3 -> rsp_err = 1, rsp_data = 0, bank unchanged.
- rst_n driven low mid-ROTATE (k=3, after step 1) -> rsp_valid = 0 immediately; all entries read 0x00 after release. With SWAP_RESP_ROT_DIR_EN, ROTATE down k=1 on {0x11,0x22,0x33,0x44} -> {0x22,0x33,0x44,0x11}.

Source files
------------

// File: rtl/swap_responder.sv
// Register-exchange responder: runs WRITE/SWAP/ROTATE/READ commands on a small register bank.
// Optional macro SWAP_RESP_ROT_DIR_EN enables downward ROTATE selected by req_data[WIDTH-1].
module swap_responder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDXW-1:0]  req_idx_a,
    input  logic [IDXW-1:0]  req_idx_b,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SWAP   = 2'b01,
        OP_ROTATE = 2'b10,
        OP_READ   = 2'b11
    } op_t;

    // DEPTH always fits in IDXW+1 bits because 2**IDXW >= DEPTH.
    localparam logic [IDXW:0] DEPTH_W = (IDXW + 1)'(DEPTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_bank      [DEPTH];
    logic [WIDTH-1:0] w_bank_next [DEPTH];
    logic [WIDTH-1:0] w_rot_up    [DEPTH];
    logic [WIDTH-1:0] w_rot_dn    [DEPTH];
    logic [IDXW-1:0]  r_rot_cnt;
    logic [IDXW-1:0]  w_rot_cnt_next;
    logic             r_rot_dir;
    logic             w_rot_dir_next;
    logic [WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0] w_rsp_data_next;
    logic             r_rsp_err;
    logic             w_rsp_err_next;
    logic             w_accept;
    logic             w_idx_err;
    logic             w_dir_in;
    logic [IDXW-1:0]  w_k;

    assign req_ready = rst_n && (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    assign w_accept  = req_valid && req_ready;
    assign w_k       = req_data[IDXW-1:0];
    assign w_idx_err = ({1'b0, req_idx_a} >= DEPTH_W) ||
                       ((op_t'(req_op) == OP_SWAP) && ({1'b0, req_idx_b} >= DEPTH_W));

`ifdef SWAP_RESP_ROT_DIR_EN
    assign w_dir_in = req_data[WIDTH-1];
`else
    assign w_dir_in = 1'b0;
`endif

    // One-step rotated images of the bank in both directions.
    always_comb begin
        w_rot_up = r_bank;
        w_rot_dn = r_bank;
        for (int i = 0; i < DEPTH; i++) begin
            w_rot_up[(i + 1) % DEPTH] = r_bank[i];
            w_rot_dn[i]               = r_bank[(i + 1) % DEPTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        w_next_state    = r_state;
        w_bank_next     = r_bank;
        w_rot_cnt_next  = r_rot_cnt;
        w_rot_dir_next  = r_rot_dir;
        w_rsp_data_next = r_rsp_data;
        w_rsp_err_next  = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state   = S_RESP;
                    w_rsp_err_next = 1'b0;
                    if (w_idx_err) begin
                        w_rsp_err_next  = 1'b1;
                        w_rsp_data_next = '0;
                    end else begin
                        case (op_t'(req_op))
                            OP_WRITE: begin
                                w_rsp_data_next        = r_bank[req_idx_a];
                                w_bank_next[req_idx_a] = req_data;
                            end
                            OP_SWAP: begin
                                // Both reads use pre-edge values, so a == b leaves the entry unchanged.
                                w_rsp_data_next        = r_bank[req_idx_a];
                                w_bank_next[req_idx_a] = r_bank[req_idx_b];
                                w_bank_next[req_idx_b] = r_bank[req_idx_a];
                            end
                            OP_ROTATE: begin
                                if (w_k == '0) begin
                                    w_rsp_data_next = r_bank[0];
                                end else begin
                                    w_rot_cnt_next = w_k;
                                    w_rot_dir_next = w_dir_in;
                                    w_next_state   = S_ROT;
                                end
                            end
                            OP_READ: begin
                                w_rsp_data_next = r_bank[req_idx_a];
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_ROT: begin
                w_bank_next    = r_rot_dir ? w_rot_dn : w_rot_up;
                w_rot_cnt_next = r_rot_cnt - 1'b1;
                if (r_rot_cnt == IDXW'(1)) begin
                    w_next_state    = S_RESP;
                    w_rsp_data_next = r_rot_dir ? w_rot_dn[0] : w_rot_up[0];
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state   = S_IDLE;
                    w_rsp_err_next = 1'b0;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bank is a flop array, not a RAM, so it can and must be cleared by reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
            r_rot_cnt  <= '0;
            r_rot_dir  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every entry take its neighbour's pre-edge value.
            r_bank     <= w_bank_next;
            r_rot_cnt  <= w_rot_cnt_next;
            r_rot_dir  <= w_rot_dir_next;
            r_rsp_data <= w_rsp_data_next;
            r_rsp_err  <= w_rsp_err_next;
        end
    end

endmodule

// File: tb/tb_swap_responder.sv
// Bench for swap_responder: a DEPTH=4 and a DEPTH=3 instance driven from one vector table,
// plus hand-written stall and mid-rotate reset sequences.
module tb_swap_responder;

    localparam logic [1:0] WR = 2'b00;
    localparam logic [1:0] SW = 2'b01;
    localparam logic [1:0] RO = 2'b10;
    localparam logic [1:0] RD = 2'b11;

    typedef struct {
        bit         sel;
        logic [1:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic [7:0] d;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid4, req_valid3;
    logic [1:0] req_op;
    logic [1:0] req_idx_a, req_idx_b;
    logic [7:0] req_data;
    logic       rsp_ready;
    logic       req_ready4, req_ready3;
    logic       rsp_valid4, rsp_valid3;
    logic [7:0] rsp_data4, rsp_data3;
    logic       rsp_err4, rsp_err3;

    bit         cur_sel;
    logic       w_ready, w_valid, w_err;
    logic [7:0] w_data;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    assign w_ready = cur_sel ? req_ready3 : req_ready4;
    assign w_valid = cur_sel ? rsp_valid3 : rsp_valid4;
    assign w_data  = cur_sel ? rsp_data3  : rsp_data4;
    assign w_err   = cur_sel ? rsp_err3   : rsp_err4;

    always #5 clk = ~clk;

    swap_responder #(.WIDTH(8), .DEPTH(4), .IDXW(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op),
        .req_idx_a(req_idx_a), .req_idx_b(req_idx_b), .req_data(req_data),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4), .rsp_err(rsp_err4)
    );

    swap_responder #(.WIDTH(8), .DEPTH(3), .IDXW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
        .req_idx_a(req_idx_a), .req_idx_b(req_idx_b), .req_data(req_data),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3), .rsp_err(rsp_err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit sel, input logic [1:0] op, input logic [1:0] a,
                                input logic [1:0] b, input logic [7:0] d, input logic [7:0] ed,
                                input logic ee, input int el, input string nm);
        vec_t v;
        v.sel = sel; v.op = op; v.a = a; v.b = b; v.d = d;
        v.exp_data = ed; v.exp_err = ee; v.exp_lat = el; v.name = nm;
        return v;
    endfunction

    task automatic issue(input bit sel, input logic [1:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic [7:0] d, input string nm);
        @(negedge clk);
        cur_sel   = sel;
        req_op    = op;
        req_idx_a = a;
        req_idx_b = b;
        req_data  = d;
        #1;
        check({nm, "_ready"}, 32'(w_ready), 32'd1);
        if (sel) req_valid3 = 1'b1;
        else     req_valid4 = 1'b1;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        req_valid4 = 1'b0;
    endtask

    // Latency counts clock edges after acceptance until rsp_valid is seen.
    task automatic wait_rsp(output logic [7:0] rd, output logic re, output int lat);
        lat = 0;
        @(negedge clk);
        while (!w_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = w_data;
        re = w_err;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rd;
        logic       re;
        int         lat;
        issue(v.sel, v.op, v.a, v.b, v.d, v.name);
        wait_rsp(rd, re, lat);
        check({v.name, "_lat"},  32'(lat), 32'(v.exp_lat));
        check({v.name, "_data"}, 32'(rd),  32'(v.exp_data));
        check({v.name, "_err"},  32'(re),  32'(v.exp_err));
        handshake();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] stall_exp;
        logic [7:0] rd;
        logic       re;
        int         lat;

        rst_n = 1'b0; req_valid4 = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b0;
        req_op = WR; req_idx_a = '0; req_idx_b = '0; req_data = '0; cur_sel = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_valid4", 32'(rsp_valid4), 32'd0);
        check("rst_ready4", 32'(req_ready4), 32'd0);
        check("rst_data4",  32'(rsp_data4),  32'd0);
        check("rst_err4",   32'(rsp_err4),   32'd0);
        check("rst_ready3", 32'(req_ready3), 32'd0);
        rst_n = 1'b1;

        // DEPTH=4 instance
        vecs.push_back(mk(0, WR, 0, 0, 8'h11, 8'h00, 0, 0, "w0"));
        vecs.push_back(mk(0, WR, 1, 0, 8'h22, 8'h00, 0, 0, "w1"));
        vecs.push_back(mk(0, WR, 2, 0, 8'h33, 8'h00, 0, 0, "w2"));
        vecs.push_back(mk(0, WR, 3, 0, 8'h44, 8'h00, 0, 0, "w3"));
        vecs.push_back(mk(0, SW, 1, 3, 8'h00, 8'h22, 0, 0, "sw13"));
        vecs.push_back(mk(0, RD, 1, 0, 8'h00, 8'h44, 0, 0, "rd1"));
        vecs.push_back(mk(0, RD, 3, 0, 8'h00, 8'h22, 0, 0, "rd3"));
        vecs.push_back(mk(0, SW, 2, 2, 8'h00, 8'h33, 0, 0, "sw22"));
        vecs.push_back(mk(0, RD, 2, 0, 8'h00, 8'h33, 0, 0, "rd2"));
        vecs.push_back(mk(0, SW, 1, 3, 8'h00, 8'h44, 0, 0, "sw13b"));
        vecs.push_back(mk(0, RO, 0, 0, 8'h01, 8'h44, 0, 1, "rot1"));
        vecs.push_back(mk(0, RO, 0, 0, 8'h03, 8'h11, 0, 3, "rot3"));
        vecs.push_back(mk(0, RO, 0, 0, 8'h00, 8'h11, 0, 0, "rot0"));
        vecs.push_back(mk(0, WR, 0, 0, 8'hA5, 8'h11, 0, 0, "w0a5"));
`ifdef SWAP_RESP_ROT_DIR_EN
        vecs.push_back(mk(0, RO, 0, 0, 8'h81, 8'h22, 0, 1, "rotdn1"));
        vecs.push_back(mk(0, RD, 1, 0, 8'h00, 8'h33, 0, 0, "rd1dn"));
        stall_exp = 8'h44;
`else
        vecs.push_back(mk(0, RO, 0, 0, 8'h81, 8'h44, 0, 1, "rotmsb1"));
        vecs.push_back(mk(0, RD, 1, 0, 8'h00, 8'hA5, 0, 0, "rd1up"));
        stall_exp = 8'h22;
`endif
        // DEPTH=3 instance: index bounds and k >= DEPTH
        vecs.push_back(mk(1, WR, 0, 0, 8'h11, 8'h00, 0, 0, "d3w0"));
        vecs.push_back(mk(1, WR, 1, 0, 8'h22, 8'h00, 0, 0, "d3w1"));
        vecs.push_back(mk(1, WR, 2, 0, 8'h33, 8'h00, 0, 0, "d3w2"));
        vecs.push_back(mk(1, SW, 0, 3, 8'h00, 8'h00, 1, 0, "d3sw03"));
        vecs.push_back(mk(1, RD, 0, 0, 8'h00, 8'h11, 0, 0, "d3rd0"));
        vecs.push_back(mk(1, RD, 3, 0, 8'h00, 8'h00, 1, 0, "d3rd3"));
        vecs.push_back(mk(1, WR, 3, 0, 8'h99, 8'h00, 1, 0, "d3w3"));
        vecs.push_back(mk(1, RD, 2, 0, 8'h00, 8'h33, 0, 0, "d3rd2"));
        vecs.push_back(mk(1, RO, 0, 0, 8'h03, 8'h11, 0, 3, "d3rot3"));
        vecs.push_back(mk(1, RO, 0, 0, 8'h02, 8'h22, 0, 2, "d3rot2"));
        vecs.push_back(mk(1, RD, 1, 3, 8'h00, 8'h33, 0, 0, "d3rd1b3"));
        vecs.push_back(mk(1, RO, 3, 0, 8'h01, 8'h00, 1, 0, "d3roterr"));
        vecs.push_back(mk(1, RD, 2, 0, 8'h00, 8'h11, 0, 0, "d3rd2b"));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response stall: outputs hold and a request pulse is not accepted.
        issue(0, RD, 2, 0, 8'h00, "stall");
        wait_rsp(rd, re, lat);
        check("stall_lat",  32'(lat), 32'd0);
        check("stall_data", 32'(rd),  32'(stall_exp));
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                req_op = WR; req_idx_a = 2'd2; req_data = 8'hEE; req_valid4 = 1'b1;
            end
            if (c == 2) req_valid4 = 1'b0;
            #1;
            check($sformatf("stall%0d_valid", c), 32'(rsp_valid4), 32'd1);
            check($sformatf("stall%0d_data", c),  32'(rsp_data4),  32'(stall_exp));
            check($sformatf("stall%0d_ready", c), 32'(req_ready4), 32'd0);
            @(negedge clk);
        end
        handshake();
        @(negedge clk);
        check("post_hs_valid", 32'(rsp_valid4), 32'd0);
        check("post_hs_ready", 32'(req_ready4), 32'd1);
        run_vec(mk(0, RD, 2, 0, 8'h00, stall_exp, 0, 0, "stall_rd2"));

        // Reset after the first step of a k=3 rotate.
        issue(0, RO, 0, 0, 8'h03, "rstrot");
        @(posedge clk);
        @(negedge clk);
        check("rstrot_busy", 32'(rsp_valid4 | req_ready4), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstrot_valid", 32'(rsp_valid4), 32'd0);
        check("rstrot_ready", 32'(req_ready4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstrot_idle_valid", 32'(rsp_valid4), 32'd0);
        for (int i = 0; i < 4; i++)
            run_vec(mk(0, RD, 2'(i), 0, 8'h00, 8'h00, 0, 0, $sformatf("zero%0d", i)));
        run_vec(mk(1, RD, 0, 0, 8'h00, 8'h00, 0, 0, "d3zero0"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
